boot_rom_arbiter: RTL and testbench
===================================

BOOT_ROM_ARBITER -- requirements
Module: boot_rom_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of addresses and data words.
REQ-002 SHALL have parameter ROM_AW, default 10: ROM word-address width, giving 1024 words.
REQ-003 SHALL have parameter ROM_BASE, default 32'h0000_0000: byte base address of the ROM window.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 i_req  in  1  instruction-fetch request.
REQ-007 i_addr  in  XLEN  fetch byte address.
REQ-008 i_gnt  out  1  fetch request accepted this cycle.
REQ-009 i_valid  out  1  fetch response valid.
REQ-010 i_rdata  out  XLEN  fetched instruction.
REQ-011 i_err  out  1  fetch response error.
REQ-012 d_req  in  1  data request.
REQ-013 d_we  in  1  data request is a write.
REQ-014 d_addr  in  XLEN  data byte address.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_valid  out  1  data response valid.
REQ-017 d_rdata  out  XLEN  read data.
REQ-018 d_err  out  1  data response error.
REQ-019 rom_en  out  1  ROM read strobe.
REQ-020 rom_addr  out  ROM_AW  ROM word address.
REQ-021 rom_rdata  in  XLEN  ROM data, valid one cycle after rom_en.

Function
REQ-022 SHALL share one single-port synchronous ROM between the fetch port and the data port, accepting at most one request per cycle.
REQ-023 i_gnt and d_gnt SHALL be combinational from the req inputs and the arbitration state, and SHALL never be high together.
REQ-024 A requester SHALL hold req and its address stable until gnt is seen high; a request is accepted on a cycle in which req and gnt are both high.
REQ-025 Only one port requesting: that port SHALL be granted in the same cycle.
REQ-026 Both ports requesting: the winner SHALL be chosen per REQ-043/REQ-044.
REQ-027 Address checks: off = addr - ROM_BASE.
  - Request is legal if addr[1:0]==0, off < 4*2^ROM_AW, and d_we==0.
  - The fetch port is always treated as a read.
REQ-028 Legal accepted request: rom_en=1 and rom_addr=off[ROM_AW+1:2] in the grant cycle T.
REQ-029 Illegal accepted request: rom_en SHALL stay 0 in cycle T.
REQ-030 The response SHALL appear in cycle T+1 on the granted port only.
  - valid=1 for exactly one cycle.
  - rdata=rom_rdata if legal, else 0.
  - err=1 if illegal, else 0.
REQ-031 A 3-state FSM SHALL track the in-flight response: IDLE, I_RSP, D_RSP.
  - Next state is I_RSP on an i grant, D_RSP on a d grant, IDLE when there is no grant.
  - Transitions are possible from every state.
REQ-032 Back-to-back grants on consecutive cycles SHALL be supported, giving a throughput of 1 request/cycle.
REQ-033 Outside valid cycles, rdata and err SHALL be 0.
REQ-034 A registered per-response err flag SHALL be held with the FSM state.
REQ-035 ROM writes SHALL never reach the ROM; a write returns d_err=1 and d_rdata=0 one cycle later.
REQ-036 The response for the last request of an offset range (off = 4*2^ROM_AW - 4) SHALL be legal.
REQ-037 off = 4*2^ROM_AW SHALL be illegal, and no address wrap-around SHALL occur.

Reset
REQ-038 While rst=1: i_gnt=d_gnt=0, rom_en=0, FSM=IDLE, error flag=0, last_winner=INSTR.
REQ-039 While rst=1: i_valid=d_valid=0 and all rdata/err outputs=0.
REQ-040 A response pending when rst rises SHALL be dropped, with no valid in the following cycle.
REQ-041 Requests held across reset SHALL be arbitrated normally from the first cycle with rst=0.
REQ-042 rom_addr SHALL be 0 whenever rom_en=0.

Configuration
REQ-043 With macro BOOT_ROM_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin.
  - The port that did not win the last contested or uncontested grant wins.
  - last_winner updates on every grant.
  - After reset, data wins the first collision.
REQ-044 With BOOT_ROM_ARB_RR_EN undefined, data SHALL have fixed priority over fetch on collision, and the last_winner register SHALL be absent.

Verification
REQ-045 Reset, then i_req=1, i_addr=0x10 with ROM word 4=0x00500093 -> i_gnt in T, rom_en=1 and rom_addr=4 in T, i_valid=1 with i_rdata=0x00500093 and i_err=0 in T+1.
REQ-046 d_req=1, d_we=1, d_addr=0x20 -> d_gnt in T, rom_en=0, d_valid=1 with d_err=1 and d_rdata=0 in T+1.
REQ-047 Address checks, each with d_we=0:
  - d_addr=0x1002 -> d_err=1.
  - d_addr=0xFFC -> legal read of word 1023.
  - d_addr=0x1000 -> d_err=1 and rom_en=0.
REQ-048 Both requesting continuously for 4 cycles:
  - RR_EN defined -> grants D,I,D,I.
  - RR_EN undefined -> grants D,D,D,D, then I after d_req drops.
REQ-049 Grant fetch at 0x8, assert rst in T+1 -> no i_valid in T+1 or T+2; after rst falls with i_req held -> a new grant in the first cycle and a correct response one cycle later.

Source files
------------

// File: rtl/boot_rom_arbiter.sv
// Shares one single-port synchronous boot ROM between an instruction-fetch port and a data port.
// Define BOOT_ROM_ARB_RR_EN for round-robin collision handling; otherwise data has fixed priority.
module boot_rom_arbiter #(
  parameter int               XLEN     = 32,
  parameter int               ROM_AW   = 10,
  parameter logic [XLEN-1:0]  ROM_BASE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_RSP = 2'd1,
    D_RSP = 2'd2
  } state_t;

  // Offset is unsigned, so addresses below the window wrap to huge values and fail the range test.
  function automatic logic addr_legal(input logic [XLEN-1:0] off, input logic we);
    addr_legal = (off[1:0] == 2'b00) &&
                 (off[XLEN-1:ROM_AW+2] == {(XLEN-ROM_AW-2){1'b0}}) &&
                 !we;
  endfunction

  state_t          state_r;
  logic            err_r;
  logic            d_pri_s;
  logic            i_gnt_s;
  logic            d_gnt_s;
  logic [XLEN-1:0] off_s;
  logic            legal_s;
  logic            rsp_i_s;
  logic            rsp_d_s;

`ifdef BOOT_ROM_ARB_RR_EN
  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  port_t last_winner_r;
  assign d_pri_s = (last_winner_r == INSTR);
`else
  assign d_pri_s = 1'b1;
`endif

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (rst) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (d_req && (!i_req || d_pri_s)) begin
      d_gnt_s = 1'b1;
    end else if (i_req) begin
      i_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  assign off_s   = (d_gnt_s ? d_addr : i_addr) - ROM_BASE;
  assign legal_s = addr_legal(off_s, d_gnt_s & d_we);

  assign i_gnt    = i_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign rom_en   = (i_gnt_s | d_gnt_s) & legal_s;
  assign rom_addr = rom_en ? off_s[ROM_AW+1:2] : {ROM_AW{1'b0}};

  // Response-tracking FSM with the per-response error flag and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
`ifdef BOOT_ROM_ARB_RR_EN
      last_winner_r <= INSTR;
`endif
    end else if (d_gnt_s) begin
      state_r <= D_RSP;
      err_r   <= !legal_s;
`ifdef BOOT_ROM_ARB_RR_EN
      last_winner_r <= DATA;
`endif
    end else if (i_gnt_s) begin
      state_r <= I_RSP;
      err_r   <= !legal_s;
`ifdef BOOT_ROM_ARB_RR_EN
      last_winner_r <= INSTR;
`endif
    end else begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end
  end

  // Reset gates the response so a pending one is dropped immediately.
  assign rsp_i_s = !rst && (state_r == I_RSP);
  assign rsp_d_s = !rst && (state_r == D_RSP);

  assign i_valid = rsp_i_s;
  assign i_err   = rsp_i_s & err_r;
  assign i_rdata = (rsp_i_s && !err_r) ? rom_rdata : {XLEN{1'b0}};
  assign d_valid = rsp_d_s;
  assign d_err   = rsp_d_s & err_r;
  assign d_rdata = (rsp_d_s && !err_r) ? rom_rdata : {XLEN{1'b0}};

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Scoreboard bench for boot_rom_arbiter: a reference model predicts grants and ROM strobes per cycle
// and queues the expected response, which is compared against the DUT one cycle later.
module tb_boot_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr;
  logic        i_gnt, i_valid, i_err, d_gnt, d_valid, d_err, rom_en;
  logic [31:0] i_rdata, d_rdata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata = 32'h0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] rd;
    logic        er;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_lw  = 1'b0;

  boot_rom_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [9:0] idx);
    if (idx == 10'd4) rom_word = 32'h0050_0093;
    else              rom_word = 32'hC0DE_0000 | {22'h0, idx};
  endfunction

  always @(posedge clk) if (rom_en) rom_rdata <= rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da);
    rsp_t        e;
    rsp_t        n;
    logic        win_d, win_i, leg;
    logic [31:0] sel, off, widx;
    @(negedge clk);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da;
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e = '{1'b0, 1'b0, 32'h0, 1'b0};
    end else begin
      e = exp_q.pop_front();
    end
    if (r) e = '{1'b0, 1'b0, 32'h0, 1'b0};
    check("i_valid", {31'h0, i_valid}, {31'h0, e.iv});
    check("i_rdata", i_rdata, e.iv ? e.rd : 32'h0);
    check("i_err",   {31'h0, i_err},   {31'h0, e.iv & e.er});
    check("d_valid", {31'h0, d_valid}, {31'h0, e.dv});
    check("d_rdata", d_rdata, e.dv ? e.rd : 32'h0);
    check("d_err",   {31'h0, d_err},   {31'h0, e.dv & e.er});

`ifdef BOOT_ROM_ARB_RR_EN
    win_d = !r && dr && (!ir || (exp_lw == 1'b0));
`else
    win_d = !r && dr;
`endif
    win_i = !r && ir && !win_d;
    sel   = win_d ? da : ia;
    off   = sel - 32'h0;
    leg   = (off % 32'd4 == 32'd0) && (off < (32'd4 << 10)) && !(win_d && dw);
    widx  = off >> 2;
    check("i_gnt",    {31'h0, i_gnt},  {31'h0, win_i});
    check("d_gnt",    {31'h0, d_gnt},  {31'h0, win_d});
    check("rom_en",   {31'h0, rom_en}, {31'h0, (win_i | win_d) & leg});
    check("rom_addr", {22'h0, rom_addr}, ((win_i | win_d) && leg) ? {22'h0, widx[9:0]} : 32'h0);

    n.iv = win_i;
    n.dv = win_d;
    n.rd = leg ? rom_word(widx[9:0]) : 32'h0;
    n.er = (win_i | win_d) && !leg;
    exp_q.push_back(n);
    if (r)          exp_lw = 1'b0;
    else if (win_d) exp_lw = 1'b1;
    else if (win_i) exp_lw = 1'b0;
    else            exp_lw = exp_lw;
  endtask

  function automatic logic [31:0] pick_addr(input int sel);
    case (sel)
      0:       pick_addr = 32'h0000_0FFC;
      1:       pick_addr = 32'h0000_1000;
      2:       pick_addr = 32'h0000_0102;
      3:       pick_addr = 32'hFFFF_FFFC;
      default: pick_addr = {20'h0, 2'b00, 10'($urandom_range(0, 1023))} << 2;
    endcase
  endfunction

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; i_addr = 32'h0; d_addr = 32'h0;
    exp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b0});

    // reset with requests held, then arbitrated from the first free cycle
    step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // fetch of word 4, write rejection, address boundaries
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1002);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // collisions for four cycles, then data drops
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80);
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // reset lands on a pending fetch response
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 80; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), pick_addr($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), pick_addr($urandom_range(0, 7)));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
